// File: rtl/reg_file.sv
// 32-entry register file with two operand read ports and a debug read port; $0 reads as zero.
// Optional same-cycle write-through to the read ports when REG_FILE_BYPASS_EN is defined.
module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    input  logic [ADDR_W-1:0] DbgReg,
    output logic [DATA_W-1:0] DbgData
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DATA_W-1:0] arr1, arr2, arr_dbg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (RegWrite && (WriteReg != '0)) begin
            regs[WriteReg] <= WriteData;
        end
    end

    // Index 0 is forced to zero on read so $0 is clean even before the first reset.
    always_comb begin
        arr1    = (ReadReg1 == '0) ? '0 : regs[ReadReg1];
        arr2    = (ReadReg2 == '0) ? '0 : regs[ReadReg2];
        arr_dbg = (DbgReg   == '0) ? '0 : regs[DbgReg];
    end

`ifdef REG_FILE_BYPASS_EN
    logic wr_live;

    // A write that will land on this edge is forwarded to any port reading the same index.
    always_comb begin
        wr_live   = rst_n && RegWrite && (WriteReg != '0);
        ReadData1 = (wr_live && (WriteReg == ReadReg1)) ? WriteData : arr1;
        ReadData2 = (wr_live && (WriteReg == ReadReg2)) ? WriteData : arr2;
        DbgData   = (wr_live && (WriteReg == DbgReg))   ? WriteData : arr_dbg;
    end
`else
    always_comb begin
        ReadData1 = arr1;
        ReadData2 = arr2;
        DbgData   = arr_dbg;
    end
`endif

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: directed cycles push expected read-port values; a negedge monitor pops and compares.
// Expectations follow REG_FILE_BYPASS_EN when the bench is built with that macro.
module tb_reg_file;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int W      = 3 * DATA_W;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic [ADDR_W-1:0] DbgReg;
    logic [DATA_W-1:0] DbgData;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    logic         chk_valid;
    int           n_tests;
    int           n_fail;

    reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2),
        .DbgReg    (DbgReg),
        .DbgData   (DbgData)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst_n     = 1'b0;
        RegWrite  = 1'b0;
        WriteReg  = '0;
        WriteData = '0;
        ReadReg1  = '0;
        ReadReg2  = '0;
        DbgReg    = '0;
        chk_valid = 1'b0;
        n_tests   = 0;
        n_fail    = 0;
    end

    // ---------------- driver ----------------
    // One call = one clock cycle: inputs set just after the edge, optional check before the next edge.
    task automatic cycle(input logic rst, input logic rw, input logic [ADDR_W-1:0] wr,
                         input logic [DATA_W-1:0] wd, input logic [ADDR_W-1:0] r1,
                         input logic [ADDR_W-1:0] r2, input logic [ADDR_W-1:0] dbg,
                         input logic chk, input logic [DATA_W-1:0] e1,
                         input logic [DATA_W-1:0] e2, input logic [DATA_W-1:0] ed,
                         input string nm);
        @(posedge clk);
        #1;
        rst_n     = rst;
        RegWrite  = rw;
        WriteReg  = wr;
        WriteData = wd;
        ReadReg1  = r1;
        ReadReg2  = r2;
        DbgReg    = dbg;
        if (chk) begin
            exp_q.push_back({e1, e2, ed});
            name_q.push_back(nm);
        end
        chk_valid = chk;
    endtask

    task automatic wr_only(input logic [ADDR_W-1:0] wr, input logic [DATA_W-1:0] wd);
        cycle(1'b1, 1'b1, wr, wd, 5'd0, 5'd0, 5'd0, 1'b0, '0, '0, '0, "");
    endtask

    function automatic logic [DATA_W-1:0] sweep_val(input int i);
        logic [DATA_W-1:0] v;
        v = (i == 0) ? '0 : 32'h0101_0101 * i[DATA_W-1:0];
        return v;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (chk_valid) begin
            logic [W-1:0] e;
            string        nm;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard_underflow: no expected entry for a checked cycle");
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_tests++;
                if (ReadData1 !== e[W-1 -: DATA_W]) begin
                    n_fail++;
                    $display("FAIL %s.ReadData1: got %h expected %h", nm, ReadData1, e[W-1 -: DATA_W]);
                end
                n_tests++;
                if (ReadData2 !== e[2*DATA_W-1 -: DATA_W]) begin
                    n_fail++;
                    $display("FAIL %s.ReadData2: got %h expected %h", nm, ReadData2, e[2*DATA_W-1 -: DATA_W]);
                end
                n_tests++;
                if (DbgData !== e[DATA_W-1:0]) begin
                    n_fail++;
                    $display("FAIL %s.DbgData: got %h expected %h", nm, DbgData, e[DATA_W-1:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset state
        cycle(1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd0, 5'd0, 1'b0, '0, '0, '0, "");
        cycle(1'b1, 1'b0, 5'd0, '0, 5'd0, 5'd5, 5'd31, 1'b1, '0, '0, '0, "reset_state");

        // Reset discards prior write; RegWrite ignored during reset
        wr_only(5'd5, 32'hDEAD_BEEF);
        cycle(1'b1, 1'b0, 5'd0, '0, 5'd5, 5'd0, 5'd5, 1'b1, 32'hDEAD_BEEF, '0, 32'hDEAD_BEEF, "pre_reset");
        cycle(1'b0, 1'b1, 5'd5, 32'h1234_5678, 5'd5, 5'd0, 5'd5, 1'b1,
              32'hDEAD_BEEF, '0, 32'hDEAD_BEEF, "reset_edge1");
        cycle(1'b0, 1'b1, 5'd5, 32'h1234_5678, 5'd5, 5'd0, 5'd5, 1'b1, '0, '0, '0, "reset_edge2");
        cycle(1'b1, 1'b0, 5'd0, '0, 5'd5, 5'd5, 5'd5, 1'b1, '0, '0, '0, "after_reset");

        // Basic write/read
        cycle(1'b1, 1'b1, 5'd8, 32'h0000_1234, 5'd8, 5'd31, 5'd0, 1'b1,
              BYP ? 32'h0000_1234 : 32'h0, '0, '0, "write8_cycle");
        cycle(1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF, 5'd8, 5'd31, 5'd31, 1'b1,
              32'h0000_1234, BYP ? 32'hFFFF_FFFF : 32'h0, BYP ? 32'hFFFF_FFFF : 32'h0, "write31_cycle");
        cycle(1'b1, 1'b0, 5'd0, '0, 5'd8, 5'd31, 5'd8, 1'b1,
              32'h0000_1234, 32'hFFFF_FFFF, 32'h0000_1234, "basic_read");

        // $0 protection
        cycle(1'b1, 1'b1, 5'd0, 32'hA5A5_A5A5, 5'd0, 5'd0, 5'd0, 1'b1, '0, '0, '0, "zero_write_cycle");
        cycle(1'b1, 1'b1, 5'd0, 32'hA5A5_A5A5, 5'd0, 5'd0, 5'd0, 1'b1, '0, '0, '0, "zero_write_again");
        cycle(1'b1, 1'b0, 5'd0, '0, 5'd0, 5'd8, 5'd0, 1'b1, '0, 32'h0000_1234, '0, "zero_after");

        // Same-cycle read/write
        wr_only(5'd3, 32'h11);
        cycle(1'b1, 1'b1, 5'd3, 32'h22, 5'd3, 5'd3, 5'd8, 1'b1,
              BYP ? 32'h22 : 32'h11, BYP ? 32'h22 : 32'h11, 32'h0000_1234, "rw_same_cycle");
        cycle(1'b1, 1'b0, 5'd0, '0, 5'd3, 5'd0, 5'd3, 1'b1, 32'h22, '0, 32'h22, "rw_after_edge");

        // RegWrite=0 leaves array untouched
        cycle(1'b1, 1'b0, 5'd9, 32'h77, 5'd9, 5'd9, 5'd9, 1'b1, '0, '0, '0, "no_write_cycle");
        cycle(1'b1, 1'b0, 5'd0, '0, 5'd9, 5'd3, 5'd9, 1'b1, '0, 32'h22, '0, "no_write_after");

        // Full sweep
        for (int i = 1; i < 32; i++) begin
            wr_only(i[ADDR_W-1:0], sweep_val(i));
        end
        for (int i = 0; i < 32; i++) begin
            cycle(1'b1, 1'b0, 5'd0, '0, i[ADDR_W-1:0], 5'(31 - i), i[ADDR_W-1:0], 1'b1,
                  sweep_val(i), sweep_val(31 - i), sweep_val(i), "sweep_read");
        end

        // Reset mid readback
        for (int i = 1; i < 6; i++) begin
            cycle(1'b1, 1'b0, 5'd0, '0, i[ADDR_W-1:0], 5'(i + 10), 5'(i + 20), 1'b1,
                  sweep_val(i), sweep_val(i + 10), sweep_val(i + 20), "sweep_pre_rst");
        end
        cycle(1'b0, 1'b0, 5'd0, '0, 5'd6, 5'd16, 5'd26, 1'b1,
              sweep_val(6), sweep_val(16), sweep_val(26), "sweep_rst_cycle");
        for (int i = 0; i < 32; i++) begin
            cycle(1'b1, 1'b0, 5'd0, '0, i[ADDR_W-1:0], 5'(31 - i), i[ADDR_W-1:0], 1'b1,
                  '0, '0, '0, "sweep_post_rst");
        end

        // Drain and report
        @(posedge clk);
        #1;
        chk_valid = 1'b0;
        @(posedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
